esc_cmd: RTL and testbench

//  Command conditioner directly upstream of the 400Hz ESC PWM generator; drives its 10-bit 'val'.

---
 rtl/esc_pkg.sv | 20 ++
 rtl/esc_frame_tick.sv | 35 +++
 rtl/esc_cmd.sv | 150 +++++++++++++++
 tb/tb_esc_cmd.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/esc_pkg.sv
// ---------------------------------------------------------------------------
// esc_pkg : shared state encoding and widths for the ESC command conditioner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package esc_pkg;
   localparam int VAL_W   = 10;
   localparam int FRAME_W = 12;
   localparam int CTR_W   = 16;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      FAILSAFE = 2'd3
   } esc_state_e;
endpackage

`default_nettype wire

// File: rtl/esc_frame_tick.sv
// ---------------------------------------------------------------------------
// esc_frame_tick : free-running frame counter, one-cycle tick on the last count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module esc_frame_tick
   import esc_pkg::*;
#(
   parameter int FRAME_US = 2500
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_US - 1);

   logic [FRAME_W-1:0] ctr_q;
   logic [FRAME_W-1:0] ctr_d;

   assign tick_o = (ctr_q == FRAME_LAST);
   assign ctr_d  = tick_o ? '0 : ctr_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctr_q <= '0;
      end else begin
         ctr_q <= ctr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/esc_cmd.sv
// ---------------------------------------------------------------------------
// esc_cmd : arm sequencing, watchdog failsafe and rising-slew limiter feeding
//           the ESC PWM stage; output only moves on frame boundaries
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module esc_cmd
   import esc_pkg::*;
#(
   parameter int FRAME_US       = 2500,
   parameter int ARM_FRAMES     = 400,
   parameter int TIMEOUT_FRAMES = 40,
   parameter int SLEW_STEP      = 16
) (
   input  logic             tmr_1Mhz,
   input  logic             rst_n,
   input  logic             arm,
   input  logic             cmd_valid,
   input  logic [VAL_W-1:0] cmd,
   output logic             cmd_ready,
   output logic [VAL_W-1:0] val,
   output logic             armed,
   output logic             failsafe
);

   localparam logic [CTR_W-1:0] ARM_LAST = CTR_W'(ARM_FRAMES - 1);
   localparam logic [CTR_W-1:0] WD_LAST  = CTR_W'(TIMEOUT_FRAMES - 1);
   localparam logic [VAL_W-1:0] STEP     = VAL_W'(SLEW_STEP);

   esc_state_e       state_q, state_d;
   logic [VAL_W-1:0] val_q, val_d;
   logic [VAL_W-1:0] target_q, target_d;
   logic [CTR_W-1:0] arm_ctr_q, arm_ctr_d;
   logic [CTR_W-1:0] wd_ctr_q, wd_ctr_d;

   logic             frame_tick;
   logic             xfer;
   logic             wd_expire;
   logic [VAL_W-1:0] diff;
   logic [VAL_W-1:0] step;
   logic [VAL_W:0]   sum;
   logic [VAL_W-1:0] slew_val;

   esc_frame_tick #(
      .FRAME_US (FRAME_US)
   ) u_frame_tick (
      .clk_i  (tmr_1Mhz),
      .rst_ni (rst_n),
      .tick_o (frame_tick)
   );

   assign cmd_ready = (state_q == ARMING) || (state_q == ARMED);
   assign xfer      = cmd_valid && cmd_ready;
   assign armed     = (state_q == ARMED);
   assign failsafe  = (state_q == FAILSAFE);
   assign val       = val_q;

   // The slew step always works from the target registered before this edge.
   assign diff     = target_q - val_q;
   assign step     = (diff > STEP) ? STEP : diff;
   assign sum      = {1'b0, val_q} + {1'b0, step};
   assign slew_val = (target_q <= val_q) ? target_q :
                     (sum[VAL_W] ? '1 : sum[VAL_W-1:0]);

   assign wd_expire = frame_tick && !xfer && (wd_ctr_q == WD_LAST);

   always_comb begin
      state_d   = state_q;
      val_d     = val_q;
      target_d  = target_q;
      arm_ctr_d = arm_ctr_q;
      wd_ctr_d  = wd_ctr_q;

      if (xfer) begin
         target_d = cmd;
      end

      unique case (state_q)
         DISARMED: begin
            val_d = '0;
            if (arm) begin
               state_d   = ARMING;
               arm_ctr_d = '0;
               target_d  = '0;
            end
         end
         ARMING: begin
            val_d = '0;
            if (!arm) begin
               state_d = DISARMED;
            end else if (frame_tick) begin
               if (arm_ctr_q == ARM_LAST) begin
                  state_d  = ARMED;
                  wd_ctr_d = '0;
               end else begin
                  arm_ctr_d = arm_ctr_q + 1'b1;
               end
            end
         end
         ARMED: begin
            if (!arm) begin
               state_d = DISARMED;
               val_d   = '0;
            end else if (wd_expire) begin
               state_d = FAILSAFE;
               val_d   = '0;
            end else begin
               if (xfer) begin
                  wd_ctr_d = '0;
               end else if (frame_tick) begin
                  wd_ctr_d = wd_ctr_q + 1'b1;
               end
               if (frame_tick) begin
                  val_d = slew_val;
               end
            end
         end
         FAILSAFE: begin
            val_d = '0;
            if (!arm) begin
               state_d = DISARMED;
            end
         end
         default: begin
            state_d = DISARMED;
            val_d   = '0;
         end
      endcase
   end

   always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DISARMED;
         val_q     <= '0;
         target_q  <= '0;
         arm_ctr_q <= '0;
         wd_ctr_q  <= '0;
      end else begin
         state_q   <= state_d;
         val_q     <= val_d;
         target_q  <= target_d;
         arm_ctr_q <= arm_ctr_d;
         wd_ctr_q  <= wd_ctr_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_esc_cmd.sv
// ---------------------------------------------------------------------------
// tb_esc_cmd : directed self-checking bench for esc_cmd (shortened frames)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_esc_cmd;

   localparam int F  = 20;
   localparam int AF = 8;
   localparam int TO = 5;
   localparam int SS = 16;

   logic       tmr_1Mhz  = 1'b0;
   logic       rst_n     = 1'b0;
   logic       arm       = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [9:0] cmd       = '0;
   logic       cmd_ready;
   logic [9:0] val;
   logic       armed;
   logic       failsafe;

   int n_checks = 0;
   int n_errors = 0;
   int fc;
   int ramp[8] = '{16, 32, 48, 64, 80, 96, 100, 100};
   int fall[4] = '{52, 68, 84, 100};

   esc_cmd #(
      .FRAME_US       (F),
      .ARM_FRAMES     (AF),
      .TIMEOUT_FRAMES (TO),
      .SLEW_STEP      (SS)
   ) dut (
      .tmr_1Mhz  (tmr_1Mhz),
      .rst_n     (rst_n),
      .arm       (arm),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_ready (cmd_ready),
      .val       (val),
      .armed     (armed),
      .failsafe  (failsafe)
   );

   always #5 tmr_1Mhz = ~tmr_1Mhz;

   // Reference frame position, used only to time stimulus around tick edges.
   always @(posedge tmr_1Mhz or negedge rst_n) begin
      if (!rst_n) fc <= 0;
      else        fc <= (fc == F - 1) ? 0 : fc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge tmr_1Mhz);
      #1;
   endtask

   // Stops on the falling edge just before a tick edge.
   task automatic to_tick_negedge();
      bit found = 1'b0;
      for (int i = 0; i < F + 2 && !found; i++) begin
         @(negedge tmr_1Mhz);
         if (fc == F - 1) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL tick_wait: got no tick expected one within %0d cycles", F + 2);
      end
   endtask

   task automatic wait_tick();
      to_tick_negedge();
      cyc();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset and disarmed command rejection
      rst_n = 1'b0; arm = 1'b0; cmd_valid = 1'b1; cmd = 10'd500;
      #12;
      chk("rst_val", val, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_armed", armed, 0);
      chk("rst_failsafe", failsafe, 0);
      @(negedge tmr_1Mhz);
      rst_n = 1'b1;
      ticks(3);
      chk("dis_val", val, 0);
      chk("dis_ready", cmd_ready, 0);
      chk("dis_armed", armed, 0);

      // Arm sequence with an early drop that restarts the count
      cmd_valid = 1'b0;
      arm = 1'b1;
      cyc();
      chk("arming_ready", cmd_ready, 1);
      chk("arming_armed", armed, 0);
      ticks(4);
      chk("arming_mid", armed, 0);
      arm = 1'b0;
      cyc();
      chk("drop_ready", cmd_ready, 0);
      arm = 1'b1;
      cyc();
      ticks(AF - 1);
      chk("arm_early", armed, 0);
      wait_tick();
      chk("arm_done", armed, 1);
      chk("arm_val", val, 0);

      // Slew-limited rise, unlimited fall
      cmd_valid = 1'b1;
      cmd = 10'd100;
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         chk($sformatf("ramp%0d", i), val, ramp[i]);
      end
      cmd = 10'd20;
      wait_tick();
      chk("fall_val", val, 20);

      // Transfer on the tick edge: step uses the previous target
      to_tick_negedge();
      cmd = 10'd200;
      cyc();
      chk("old_target", val, 20);
      wait_tick();
      chk("new_target", val, 36);

      // Command loss -> failsafe after TO ticks
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         chk($sformatf("wd_ramp%0d", i), val, fall[i]);
      end
      chk("wd_armed", armed, 1);
      wait_tick();
      chk("fs_flag", failsafe, 1);
      chk("fs_val", val, 0);
      chk("fs_ready", cmd_ready, 0);
      chk("fs_armed", armed, 0);
      ticks(2);
      chk("fs_hold", failsafe, 1);
      arm = 1'b0;
      cyc();
      chk("fs_exit", failsafe, 0);
      chk("fs_exit_armed", armed, 0);

      // Transfer on the expiry tick keeps ARMED
      arm = 1'b1;
      cyc();
      ticks(AF);
      chk("rearm", armed, 1);
      ticks(TO - 1);
      to_tick_negedge();
      cmd_valid = 1'b1;
      cmd = 10'd50;
      cyc();
      cmd_valid = 1'b0;
      chk("expiry_xfer_armed", armed, 1);
      chk("expiry_xfer_val", val, 0);
      wait_tick();
      chk("post_xfer_val", val, 16);
      ticks(3);
      chk("pre_expiry_val", val, 50);
      chk("pre_expiry_armed", armed, 1);

      // arm drop coincident with timeout: disarm wins
      to_tick_negedge();
      arm = 1'b0;
      cyc();
      chk("drop_vs_to_fs", failsafe, 0);
      chk("drop_vs_to_armed", armed, 0);
      chk("drop_vs_to_val", val, 0);

      // Async reset mid-ramp
      arm = 1'b1;
      cmd_valid = 1'b1;
      cmd = 10'd300;
      cyc();
      ticks(AF);
      chk("r6_armed", armed, 1);
      ticks(4);
      chk("r6_val64", val, 64);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_val", val, 0);
      chk("async_armed", armed, 0);
      chk("async_ready", cmd_ready, 0);
      @(negedge tmr_1Mhz);
      rst_n = 1'b1;
      cyc();
      ticks(AF - 1);
      chk("post_rst_early", armed, 0);
      wait_tick();
      chk("post_rst_armed", armed, 1);
      chk("post_rst_val", val, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
